pool_ofm_collector: RTL and testbench

Downstream stage of the pooling engine. Takes the unthrottled pooled-result stream (one word per valid cycle, no backpressure) and applies optional ReLU. Buffers results in a synchronous FIFO and re-emits them on a valid/ready interface, tagged with column, row and channel boundary flags. Also checks the pooling engine's end-of-frame pulse against the expected OFM size, so a frame-length mismatch is flagged instead of silently corrupting the next layer.

---
 rtl/pool_ofm_collector_pkg.sv | 11 +
 rtl/sync_fifo.sv | 37 +++
 rtl/pool_ofm_collector.sv | 99 +++++++++
 tb/tb_pool_ofm_collector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_ofm_collector_pkg.sv
// pool_ofm_collector_pkg: tag positions, FSM states and counter-width helper for the OFM collector
package pool_ofm_collector_pkg;
   localparam int TAG_COL = 0;
   localparam int TAG_ROW = 1;
   localparam int TAG_CH  = 2;
   localparam int TAG_W   = 3;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered pointers, combinational head read, push+pop allowed when full
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/pool_ofm_collector.sv
// pool_ofm_collector: ReLU, boundary tagging, buffering and frame-length check of pooled results
module pool_ofm_collector
   import pool_ofm_collector_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OFM_SIZE   = 23,
   parameter int CI         = 3,
   parameter int FIFO_DEPTH = 32,
   parameter int RELU       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_end,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last_col,
   output logic                  out_last_row,
   output logic                  out_last_ch,
   output logic                  frame_done,
   output logic                  overflow,
   output logic                  len_err,
   output logic                  busy
);
   localparam int CW = cnt_w(OFM_SIZE);
   localparam int HW = cnt_w(CI);
   localparam int EW = DATA_WIDTH + TAG_W;
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] SIDE_MAX = CW'(OFM_SIZE - 1);
   localparam logic [HW-1:0] CH_MAX = HW'(CI - 1);
   state_t state;
   logic [CW-1:0] col, row;
   logic [HW-1:0] ch;
   logic [TAG_W-1:0] tags;
   logic [DATA_WIDTH-1:0] wdata;
   logic [EW-1:0] head;
   logic [FW-1:0] fifo_cnt;
   logic fifo_full, fifo_empty, pop, accept, frame_last, cnt_nz, mid_end;
   assign tags[TAG_COL] = col == SIDE_MAX;
   assign tags[TAG_ROW] = row == SIDE_MAX;
   assign tags[TAG_CH] = ch == CH_MAX;
   assign frame_last = &tags;
   assign cnt_nz = |{col, row, ch};
   assign mid_end = in_end && cnt_nz;
   assign wdata = (RELU != 0 && in_data[DATA_WIDTH-1]) ? '0 : in_data;
   assign out_valid = fifo_cnt != '0;
   assign pop = out_valid && out_ready;
   assign accept = in_valid && (!fifo_full || pop);
   assign {out_last_ch, out_last_row, out_last_col, out_data} = out_valid ? head : '0;
   assign busy = state != IDLE;
   assign frame_done = state == DONE;
   sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   ({tags, wdata}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );
   // dropped beats still advance the counters so framing stays aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
         ch <= '0;
         overflow <= 1'b0;
         len_err <= 1'b0;
      end else begin
         if (mid_end) begin
            col <= '0;
            row <= '0;
            ch <= '0;
         end else if (in_valid) begin
            col <= tags[TAG_COL] ? '0 : col + CW'(1);
            if (tags[TAG_COL]) row <= tags[TAG_ROW] ? '0 : row + CW'(1);
            if (tags[TAG_COL] && tags[TAG_ROW]) ch <= tags[TAG_CH] ? '0 : ch + HW'(1);
         end
         if (in_valid && !accept) overflow <= 1'b1;
         if (mid_end) len_err <= 1'b1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else begin
         case (state)
            IDLE:    if (in_valid) state <= frame_last ? DRAIN : RUN;
            RUN:     if ((in_valid && frame_last) || mid_end) state <= DRAIN;
            DRAIN:   if (fifo_empty) state <= DONE;
            DONE:    state <= (!fifo_empty || cnt_nz || in_valid) ? RUN : IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pool_ofm_collector.sv
// tb_pool_ofm_collector: randomized scenarios checked against a queue-based frame model
module tb_pool_ofm_collector;
   localparam int S = 3;
   localparam int C = 2;
   localparam int D = 4;
   localparam int FRAME = S * S * C;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_end = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic out_valid, out_last_col, out_last_row, out_last_ch, frame_done, overflow, len_err, busy;
   logic [31:0] out_data;
   logic out_valid0, out_last_col0, out_last_row0, out_last_ch0, frame_done0, overflow0, len_err0, busy0;
   logic [31:0] out_data0;
   logic [37:0] obs, obs0, exp_obs, exp_obs0;
   logic [34:0] q[$];
   int pos, total, bad, fd_cnt;
   bit m_ovf, m_len;
   always #5 clk = ~clk;
   pool_ofm_collector #(.DATA_WIDTH(32), .OFM_SIZE(S), .CI(C), .FIFO_DEPTH(D), .RELU(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last_col(out_last_col), .out_last_row(out_last_row), .out_last_ch(out_last_ch),
      .frame_done(frame_done), .overflow(overflow), .len_err(len_err), .busy(busy)
   );
   pool_ofm_collector #(.DATA_WIDTH(32), .OFM_SIZE(S), .CI(C), .FIFO_DEPTH(D), .RELU(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_end(in_end),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_last_col(out_last_col0), .out_last_row(out_last_row0), .out_last_ch(out_last_ch0),
      .frame_done(frame_done0), .overflow(overflow0), .len_err(len_err0), .busy(busy0)
   );
   assign obs = {out_valid, out_last_ch, out_last_row, out_last_col, out_data, overflow, len_err};
   assign obs0 = {out_valid0, out_last_ch0, out_last_row0, out_last_col0, out_data0, overflow0, len_err0};
   function automatic logic [31:0] relu(input logic [31:0] d);
      return ($signed(d) < 0) ? 32'd0 : d;
   endfunction
   function automatic logic [2:0] tag_of(input int p);
      int c, r, h;
      c = p % S;
      r = (p / S) % S;
      h = p / (S * S);
      return {h == C - 1, r == S - 1, c == S - 1};
   endfunction
   // drive one cycle, capture the expectation for what is visible now, then advance the model
   task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic e);
      bit pp, acc;
      @(posedge clk);
      #1;
      in_valid = v;
      in_data = d;
      out_ready = rdy;
      in_end = e;
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      if (q.size() > 0) begin
         exp_obs = {1'b1, q[0][34:32], relu(q[0][31:0]), m_ovf, m_len};
         exp_obs0 = {1'b1, q[0], m_ovf, m_len};
      end else begin
         exp_obs = {36'd0, m_ovf, m_len};
         exp_obs0 = exp_obs;
      end
      pp = q.size() > 0 && rdy;
      acc = v && (q.size() < D || pp);
      if (pp) void'(q.pop_front());
      if (v) begin
         if (acc) q.push_back({tag_of(pos), d});
         else m_ovf = 1'b1;
      end
      if (e && pos != 0) begin
         m_len = 1'b1;
         pos = 0;
      end else if (v) pos = (pos + 1) % FRAME;
   endtask
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      in_end = 1'b0;
      out_ready = 1'b0;
      in_data = '0;
      q.delete();
      pos = 0;
      m_ovf = 1'b0;
      m_len = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   task automatic test_reset();
      #12;
      total++;
      if (obs !== 38'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL reset: got obs=%h busy=%b done=%b want all zero", obs, busy, frame_done);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   task automatic test_frame();
      for (int i = 1; i <= FRAME; i++) begin
         step(1'b1, 32'(i), 1'b1, 1'b0);
         total += 2;
         if (obs !== exp_obs) begin bad++; $display("FAIL frame beat %0d: got %h want %h", i, obs, exp_obs); end
         if (busy !== (i > 1)) begin bad++; $display("FAIL frame busy %0d: got %b want %b", i, busy, i > 1); end
      end
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         total += 3;
         if (obs !== exp_obs) begin bad++; $display("FAIL frame tail %0d: got %h want %h", i, obs, exp_obs); end
         if (frame_done !== (i == 3)) begin bad++; $display("FAIL frame_done %0d: got %b want %b", i, frame_done, i == 3); end
         if (busy !== (i < 4)) begin bad++; $display("FAIL frame idle busy %0d: got %b want %b", i, busy, i < 4); end
      end
   endtask
   task automatic test_relu();
      logic [31:0] vals [3];
      vals[0] = -32'sd5;
      vals[1] = 32'd0;
      vals[2] = 32'd7;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(i < 3, (i < 3) ? vals[i % 3] : 32'd0, 1'b1, 1'b0);
         total += 2;
         if (obs !== exp_obs) begin bad++; $display("FAIL relu1 %0d: got %h want %h", i, obs, exp_obs); end
         if (obs0 !== exp_obs0) begin bad++; $display("FAIL relu0 %0d: got %h want %h", i, obs0, exp_obs0); end
      end
   endtask
   task automatic test_overflow();
      int got;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step(i < 6, $urandom, 1'b0, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL ovf fill %0d: got %h want %h", i, obs, exp_obs); end
      end
      total++;
      if (overflow !== 1'b1) begin bad++; $display("FAIL ovf flag: got %b want 1", overflow); end
      got = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         if (out_valid === 1'b1) got++;
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL ovf drain %0d: got %h want %h", i, obs, exp_obs); end
      end
      total++;
      if (got !== 4) begin bad++; $display("FAIL ovf words: got %0d want 4", got); end
      for (int i = 0; i < 12 + FRAME + 4; i++) begin
         step(i < 12 + FRAME, $urandom, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL ovf next frame %0d: got %h want %h", i, obs, exp_obs); end
      end
   endtask
   task automatic test_full_pushpop();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(i < 5, $urandom, i == 4, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL full pp %0d: got %h want %h", i, obs, exp_obs); end
      end
      total++;
      if (dut.fifo_cnt !== 3'd4) begin bad++; $display("FAIL full occupancy: got %0d want 4", dut.fifo_cnt); end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL full drain %0d: got %h want %h", i, obs, exp_obs); end
      end
   endtask
   task automatic test_len_err();
      int fd0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, $urandom, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL len beat %0d: got %h want %h", i, obs, exp_obs); end
      end
      fd0 = fd_cnt;
      step(1'b0, 32'd0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL len drain %0d: got %h want %h", i, obs, exp_obs); end
      end
      total += 2;
      if (len_err !== 1'b1) begin bad++; $display("FAIL len_err flag: got %b want 1", len_err); end
      if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL len done pulses: got %0d want 1", fd_cnt - fd0); end
      fd0 = fd_cnt;
      step(1'b0, 32'd0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 32'd0, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL len boundary %0d: got %h want %h", i, obs, exp_obs); end
      end
      total += 2;
      if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL len extra pulse: got %0d want 0", fd_cnt - fd0); end
      if (busy !== 1'b0) begin bad++; $display("FAIL len busy: got %b want 0", busy); end
   endtask
   task automatic test_rst_mid();
      int fd0;
      do_reset();
      for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      total += 3;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst busy: got %b want 0", busy); end
      if (overflow !== 1'b0) begin bad++; $display("FAIL rst overflow: got %b want 0", overflow); end
      q.delete();
      pos = 0;
      m_ovf = 1'b0;
      m_len = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      fd0 = fd_cnt;
      for (int i = 0; i < FRAME + 6; i++) begin
         step(i < FRAME, $urandom, 1'b1, 1'b0);
         total++;
         if (obs !== exp_obs) begin bad++; $display("FAIL rst frame %0d: got %h want %h", i, obs, exp_obs); end
      end
      total++;
      if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL rst done pulses: got %0d want 1", fd_cnt - fd0); end
   endtask
   task automatic test_random();
      do_reset();
      for (int i = 0; i < 320; i++) begin
         step(i < 300 && $urandom_range(3, 0) != 0, $urandom, i >= 300 || $urandom_range(2, 0) != 0, 1'b0);
         total += 2;
         if (obs !== exp_obs) begin bad++; $display("FAIL random %0d: got %h want %h", i, obs, exp_obs); end
         if (obs0 !== exp_obs0) begin bad++; $display("FAIL random raw %0d: got %h want %h", i, obs0, exp_obs0); end
      end
   endtask
   initial begin
      test_reset();
      test_frame();
      test_relu();
      test_overflow();
      test_full_pushpop();
      test_len_err();
      test_rst_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
